slot_ptr_bank: RTL

- Parametrised successor to the single-pointer slot-card register block.
- Holds NCH independent auto-stepping memory pointers, each AW bits wide, in the card's 16-byte DEVSEL space.
- Each pointer has a per-channel step mode (increment, decrement, hold) and a data port that reaches SRAM through RA.
- Also gates slot ROM ($CnXX via /IOSEL, $C800 via /IOSTRB with a $CFFF release) and controls the data-bus drivers.

---
 rtl/slot_ptr_bank.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/slot_ptr_bank.sv
// slot_ptr_bank: NCH auto-stepping SRAM pointers in DEVSEL space, slot ROM gating and bus drive control.
// Optional build macro CARRY_FIXUP_EN: a low-first pointer byte write can schedule the carry into the next byte.
module slot_ptr_bank #(
    parameter int AW  = 24,
    parameter int NCH = 2,
    parameter int RAW = 20
) (
    input  logic           C7M,
    input  logic           nRES,
    input  logic           PHI1,
    input  logic [10:0]    A,
    input  logic           nWE,
    input  logic           nDEVSEL,
    input  logic           nIOSEL,
    input  logic           nIOSTRB,
    input  logic [7:0]     Din,
    input  logic [7:0]     RDin,
    output logic [7:0]     Dout,
    output logic           DOE,
    output logic [7:0]     RDout,
    output logic           RDOE,
    output logic [RAW-1:0] RA,
    output logic           RAMCS,
    output logic           nROMCS
);
    localparam int NB = AW / 8;
    localparam int CW = 2 * NCH;
    localparam logic [2:0] BYTE_MASK = (NB == 1) ? 3'b001 : (NB == 2) ? 3'b011 : 3'b111;

    logic [1:0]             phi1_q, phi1_d;
    logic [2:0]             s_q, s_d;
    logic                   csdben_q, csdben_d;
    logic                   regen_q, regen_d;
    logic                   ioromen_q, ioromen_d;
    logic                   bank_q, bank_d;
    logic [1:0]             act_q, act_d;
    logic [CW-1:0]          ctrl_q, ctrl_d;
    logic [NCH-1:0][AW-1:0] ptr_q, ptr_d;
    // Per channel pending step flags, bit k steps pointer byte k: {IncH, IncM, IncL}
    logic [NCH-1:0][2:0]    step_q, step_d;

    logic [1:0]     ch, bsel;
    logic           dev_sel, dport_sel, rom_sel;
    logic [7:0]     reg_rd;
    logic [RAW-1:0] ra_mux;

    assign ch        = A[3:2];
    assign bsel      = A[1:0];
    assign dev_sel   = ~nDEVSEL & regen_q;
    assign dport_sel = dev_sel && (bsel == 2'd3) && (int'(ch) < NCH);
    assign rom_sel   = ~nIOSEL | (~nIOSTRB & ioromen_q);

    always_comb begin
        logic [1:0] mode;
        logic [7:0] byte_old;
        mode      = 2'b00;
        byte_old  = 8'h00;
        phi1_d    = {phi1_q[0], PHI1};
        csdben_d  = s_q[2];
        regen_d   = regen_q | ((s_q == 3'd5) & ~nIOSEL);
        ioromen_d = ioromen_q;
        bank_d    = bank_q;
        act_d     = act_q;
        ctrl_d    = ctrl_q;
        ptr_d     = ptr_q;
        step_d    = step_q;

        if (!phi1_q[1] && phi1_q[0])
            s_d = 3'd1;
        else if (s_q == 3'd0 || s_q == 3'd7)
            s_d = s_q;
        else
            s_d = s_q + 3'd1;

        if (s_q == 3'd5 && !nIOSEL)
            ioromen_d = 1'b1;
        if (!nIOSTRB && A == 11'h7FF)
            ioromen_d = 1'b0;

        // Byte k steps on phase S(k+1); the mode is read at that moment, not when scheduled
        for (int c = 0; c < NCH; c++) begin
            mode = ctrl_q[2*c +: 2];
            for (int k = 0; k < NB; k++) begin
                if (int'(s_q) == k + 1 && step_q[c][k]) begin
                    step_d[c][k] = 1'b0;
                    if (!mode[1]) begin
                        byte_old = ptr_q[c][8*k +: 8];
                        ptr_d[c][8*k +: 8] = mode[0] ? byte_old - 8'd1 : byte_old + 8'd1;
                        if (byte_old == (mode[0] ? 8'h00 : 8'hFF))
                            step_d[c] = step_d[c] | ((3'b001 << (k + 1)) & BYTE_MASK);
                    end
                end
            end
        end

        if (s_q == 3'd6 && dev_sel) begin
            for (int c = 0; c < NCH; c++) begin
                if (ch == 2'(c)) begin
                    mode = ctrl_q[2*c +: 2];
                    if (bsel == 2'd3) begin
                        act_d = 2'(c);
                        if (!mode[1])
                            step_d[c][0] = 1'b1;
                    end else if (!nWE) begin
                        for (int k = 0; k < NB; k++) begin
                            if (bsel == 2'(k)) begin
                                byte_old = ptr_q[c][8*k +: 8];
                                ptr_d[c][8*k +: 8] = Din;
                                step_d[c][2:1] = 2'b00;
`ifdef CARRY_FIXUP_EN
                                if (!mode[1] && (mode[0] ? (!byte_old[7] && Din[7])
                                                         : (byte_old[7] && !Din[7])))
                                    step_d[c] = step_d[c] | ((3'b001 << (k + 1)) & BYTE_MASK);
`endif
                            end
                        end
                    end
                end
            end
            if (!nWE && A[3:0] == 4'hC)
                ctrl_d = Din[CW-1:0];
            if (!nWE && A[3:0] == 4'hF)
                bank_d = Din[0];
        end
    end

    always_ff @(posedge C7M or negedge nRES) begin
        if (!nRES) begin
            phi1_q    <= '0;
            s_q       <= '0;
            csdben_q  <= 1'b0;
            regen_q   <= 1'b0;
            ioromen_q <= 1'b0;
            bank_q    <= 1'b0;
            act_q     <= '0;
            ctrl_q    <= '0;
            ptr_q     <= '0;
            step_q    <= '0;
        end else begin
            phi1_q    <= phi1_d;
            s_q       <= s_d;
            csdben_q  <= csdben_d;
            regen_q   <= regen_d;
            ioromen_q <= ioromen_d;
            bank_q    <= bank_d;
            act_q     <= act_d;
            ctrl_q    <= ctrl_d;
            ptr_q     <= ptr_d;
            step_q    <= step_d;
        end
    end

    always_comb begin
        reg_rd = 8'h00;
        if (regen_q) begin
            for (int c = 0; c < NCH; c++)
                for (int k = 0; k < NB; k++)
                    if (ch == 2'(c) && bsel == 2'(k))
                        reg_rd = ptr_q[c][8*k +: 8];
            if (A[3:0] == 4'hC)
                reg_rd = 8'(ctrl_q);
        end
    end

    // Slot ROM cycles address by {Bank, A}; otherwise the active channel's pointer drives RA
    always_comb begin
        ra_mux = '0;
        if (!nIOSEL || !nIOSTRB)
            ra_mux = RAW'({bank_q, A});
        else
            for (int c = 0; c < NCH; c++)
                if (act_q == 2'(c))
                    ra_mux = ptr_q[c][RAW-1:0];
    end

    assign RA     = nRES ? ra_mux : '0;
    assign RAMCS  = csdben_q & dport_sel;
    assign nROMCS = ~(csdben_q & rom_sel);
    assign RDOE   = csdben_q & ~nWE;
    assign RDout  = Din;
    assign DOE    = csdben_q & nWE & (dev_sel | rom_sel);
    assign Dout   = (dport_sel | rom_sel) ? RDin : reg_rd;
endmodule
